// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI command decoder.
//   spi_cmd_t        - command byte (byte0 of a frame)
//   status_reg_t     - status byte from the safety core
//   control_reg_t    - layout of the WRITE_CONTROL argument byte
//   contactor_data_t - READ_FEEDBACK response layout
//   SPI_WORD_LENGTH  - bits per SPI byte slot
//   RESP_INVALID     - response for an out-of-range index
package spi_pkg;

  localparam int         SPI_WORD_LENGTH = 8;
  localparam logic [7:0] RESP_INVALID    = 8'hFF;

  typedef enum logic [7:0] {
    CMD_VERSION           = 8'h00,
    CMD_READ_CONTACTOR    = 8'h01,
    CMD_READ_FEEDBACK     = 8'h02,
    CMD_READ_STATUS       = 8'h03,
    CMD_READ_SHUTDOWN     = 8'h04,
    CMD_READ_CONTROL      = 8'h05,
    CMD_WRITE_CONTACTOR   = 8'h81,
    CMD_WRITE_CONTROL     = 8'h82,
    CMD_WRITE_SHUTDOWN    = 8'h83,
    CMD_WRITE_PG_SHUTDOWN = 8'h84
  } spi_cmd_t;

  typedef struct packed {
    logic       fault;
    logic       invalid_request;
    logic [5:0] core_flags;
  } status_reg_t;

  typedef struct packed {
    logic [5:0] reserved;
    logic       clear_errors;
    logic       reset_req;
  } control_reg_t;

  typedef struct packed {
    logic [5:0] reserved;
    logic       plus;
    logic       minus;
  } contactor_data_t;

  function automatic logic is_known_cmd(input logic [7:0] b);
    case (b)
      CMD_VERSION, CMD_READ_CONTACTOR, CMD_READ_FEEDBACK, CMD_READ_STATUS,
      CMD_READ_SHUTDOWN, CMD_READ_CONTROL, CMD_WRITE_CONTACTOR,
      CMD_WRITE_CONTROL, CMD_WRITE_SHUTDOWN, CMD_WRITE_PG_SHUTDOWN:
        is_known_cmd = 1'b1;
      default:
        is_known_cmd = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/spi_cmd_decoder_if.sv
// Byte-level SPI bus between the SPI shifter (master side) and the decoder.
//   cs_active - frame in progress (synchronised chip select)
//   rx_valid  - one-cycle strobe, rx_data holds a received byte
//   rx_data   - received byte
//   tx_load   - one-cycle strobe, tx_data goes into the next byte slot
//   tx_data   - response byte
interface spi_cmd_decoder_if;
  import spi_pkg::*;

  logic                       cs_active;
  logic                       rx_valid;
  logic [SPI_WORD_LENGTH-1:0] rx_data;
  logic                       tx_load;
  logic [SPI_WORD_LENGTH-1:0] tx_data;

  modport master (output cs_active, rx_valid, rx_data, input  tx_load, tx_data);
  modport slave  (input  cs_active, rx_valid, rx_data, output tx_load, tx_data);
endinterface

// File: rtl/spi_resp_mux.sv
// Combinational response selection for the decoder.
//   i_cmd        - latched command byte
//   i_arg        - argument byte (byte1)
//   i_contactor  - current contactor command vector
//   i_feedback   - {plus,minus} feedback per contactor
//   i_status     - status byte from the safety core
//   i_invalid    - current invalid_request flag
//   i_shutdown   - shutdown register
//   i_control    - stored control register
//   o_resp       - response byte
//   o_idx_bad    - indexed command addresses a non-existent contactor
//   o_sel        - decoded contactor index
module spi_resp_mux
  import spi_pkg::*;
#(
  parameter int         NUM_CONTACTORS = 8,
  parameter logic [7:0] FPGA_VERSION   = 8'h01,
  localparam int        IDX_W          = (NUM_CONTACTORS > 1) ? $clog2(NUM_CONTACTORS) : 1
) (
  input  spi_cmd_t                      i_cmd,
  input  logic [7:0]                    i_arg,
  input  logic [NUM_CONTACTORS-1:0]     i_contactor,
  input  logic [2*NUM_CONTACTORS-1:0]   i_feedback,
  input  logic [7:0]                    i_status,
  input  logic                          i_invalid,
  input  logic [7:0]                    i_shutdown,
  input  logic [7:0]                    i_control,
  output logic [7:0]                    o_resp,
  output logic                          o_idx_bad,
  output logic [IDX_W-1:0]              o_sel
);

  localparam logic [8:0] NUM_W = 9'(NUM_CONTACTORS);

  logic [7:0]       w_idx;
  logic             w_uses_idx;
  logic [IDX_W-1:0] w_sel;
  status_reg_t      w_st;
  contactor_data_t  w_fb;

  // WRITE_CONTACTOR packs the index above the value bit; reads use the whole byte.
  always_comb begin
    w_idx      = i_arg;
    w_uses_idx = 1'b0;
    case (i_cmd)
      CMD_READ_CONTACTOR, CMD_READ_FEEDBACK: w_uses_idx = 1'b1;
      CMD_WRITE_CONTACTOR: begin
        w_uses_idx = 1'b1;
        w_idx      = {1'b0, i_arg[7:1]};
      end
      default: ;
    endcase
  end

  assign o_idx_bad = w_uses_idx && ({1'b0, w_idx} >= NUM_W);
  assign w_sel     = w_idx[IDX_W-1:0];
  assign o_sel     = w_sel;

  always_comb begin
    // The core's invalid_request bit is replaced by the decoder's own flag.
    w_st                 = status_reg_t'(i_status);
    w_st.invalid_request = i_invalid;
    w_fb                 = '0;
    {w_fb.plus, w_fb.minus} = i_feedback[2*int'(w_sel) +: 2];

    o_resp = RESP_INVALID;
    case (i_cmd)
      CMD_VERSION:           o_resp = FPGA_VERSION;
      CMD_READ_CONTACTOR:    o_resp = {7'b0, i_contactor[w_sel]};
      CMD_READ_FEEDBACK:     o_resp = w_fb;
      CMD_READ_STATUS:       o_resp = w_st;
      CMD_READ_SHUTDOWN:     o_resp = i_shutdown;
      CMD_READ_CONTROL:      o_resp = i_control;
      CMD_WRITE_CONTACTOR,
      CMD_WRITE_CONTROL,
      CMD_WRITE_SHUTDOWN,
      CMD_WRITE_PG_SHUTDOWN: o_resp = i_arg;
      default:               o_resp = RESP_INVALID;
    endcase
    if (o_idx_bad) o_resp = RESP_INVALID;
  end

endmodule

// File: rtl/spi_cmd_decoder.sv
// Two-byte SPI command decoder: byte0 = command, byte1 = index / write data.
// The response is presented with a tx_load strobe one clock after byte1.
//   clk, rst_n        - system clock, asynchronous active-low reset
//   spi               - byte-level SPI bus (slave side)
//   feedback_i        - {plus,minus} feedback per contactor
//   status_i          - status byte from the safety core
//   contactor_cmd_o   - commanded contactor states
//   shutdown_o        - shutdown command register
//   pg_shutdown_o     - direct PG shutdown request
//   reset_req_o       - single-cycle pulse from WRITE_CONTROL bit0
//   clear_errors_o    - single-cycle pulse from WRITE_CONTROL bit1
//   invalid_request_o - sticky protocol error flag
module spi_cmd_decoder
  import spi_pkg::*;
#(
  parameter int         NUM_CONTACTORS = 8,
  parameter logic [7:0] FPGA_VERSION   = 8'h01
) (
  input  logic                        clk,
  input  logic                        rst_n,
  spi_cmd_decoder_if.slave            spi,
  input  logic [2*NUM_CONTACTORS-1:0] feedback_i,
  input  logic [7:0]                  status_i,
  output logic [NUM_CONTACTORS-1:0]   contactor_cmd_o,
  output logic [7:0]                  shutdown_o,
  output logic                        pg_shutdown_o,
  output logic                        reset_req_o,
  output logic                        clear_errors_o,
  output logic                        invalid_request_o
);

  localparam int IDX_W = (NUM_CONTACTORS > 1) ? $clog2(NUM_CONTACTORS) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_ARG, ST_RESP, ST_DRAIN} state_t;

  state_t                    r_state, w_state_nxt;
  spi_cmd_t                  r_cmd;
  logic                      r_armed;
  logic                      r_tx_load;
  logic [7:0]                r_tx_data;
  logic [NUM_CONTACTORS-1:0] r_contactor;
  logic [7:0]                r_shutdown;
  logic                      r_pg_shutdown;
  logic [7:0]                r_control;
  logic                      r_reset_req;
  logic                      r_clear_errors;
  logic                      r_invalid;

  logic             w_rx;
  logic             w_latch_cmd;
  logic             w_bad_cmd;
  logic             w_exec;
  logic [7:0]       w_resp;
  logic             w_idx_bad;
  logic [IDX_W-1:0] w_sel;
  logic             w_err_set;
  logic             w_err_clr;

  // A byte strobe arriving as CS drops belongs to no frame.
  assign w_rx = spi.rx_valid & spi.cs_active;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_latch_cmd = 1'b0;
    w_bad_cmd   = 1'b0;
    w_exec      = 1'b0;
    if (!spi.cs_active) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // After reset, a frame already in flight is not joined halfway.
          if (w_rx && r_armed) begin
            w_latch_cmd = 1'b1;
            if (is_known_cmd(spi.rx_data)) begin
              w_state_nxt = ST_ARG;
            end else begin
              w_bad_cmd   = 1'b1;
              w_state_nxt = ST_DRAIN;
            end
          end
        end
        ST_ARG: begin
          if (w_rx) begin
            w_exec      = 1'b1;
            w_state_nxt = ST_RESP;
          end
        end
        ST_RESP: begin
          if (w_rx) w_state_nxt = ST_DRAIN;
        end
        default: ;
      endcase
    end
  end

  spi_resp_mux #(
    .NUM_CONTACTORS (NUM_CONTACTORS),
    .FPGA_VERSION   (FPGA_VERSION)
  ) u_resp_mux (
    .i_cmd       (r_cmd),
    .i_arg       (spi.rx_data),
    .i_contactor (r_contactor),
    .i_feedback  (feedback_i),
    .i_status    (status_i),
    .i_invalid   (r_invalid),
    .i_shutdown  (r_shutdown),
    .i_control   (r_control),
    .o_resp      (w_resp),
    .o_idx_bad   (w_idx_bad),
    .o_sel       (w_sel)
  );

  // A new error in the same cycle as a clear request keeps the flag set.
  assign w_err_set = w_bad_cmd | (w_exec & w_idx_bad);
  assign w_err_clr = w_exec && (r_cmd == CMD_WRITE_CONTROL) && spi.rx_data[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cmd          <= CMD_VERSION;
      r_armed        <= 1'b0;
      r_tx_load      <= 1'b0;
      r_tx_data      <= 8'h00;
      r_contactor    <= '0;
      r_shutdown     <= 8'h00;
      r_pg_shutdown  <= 1'b0;
      r_control      <= 8'h00;
      r_reset_req    <= 1'b0;
      r_clear_errors <= 1'b0;
      r_invalid      <= 1'b0;
    end else begin
      r_armed        <= r_armed | ~spi.cs_active;
      r_tx_load      <= w_exec;
      r_reset_req    <= 1'b0;
      r_clear_errors <= 1'b0;

      if (w_latch_cmd) r_cmd <= spi_cmd_t'(spi.rx_data);
      if (w_exec)      r_tx_data <= w_resp;

      if (w_exec && !w_idx_bad) begin
        case (r_cmd)
          CMD_WRITE_CONTACTOR:   r_contactor[w_sel] <= spi.rx_data[0];
          CMD_WRITE_CONTROL: begin
            // Pulse bits act once and are not retained.
            r_control      <= {spi.rx_data[7:2], 2'b00};
            r_reset_req    <= spi.rx_data[0];
            r_clear_errors <= spi.rx_data[1];
          end
          CMD_WRITE_SHUTDOWN:    r_shutdown    <= spi.rx_data;
          CMD_WRITE_PG_SHUTDOWN: r_pg_shutdown <= spi.rx_data[0];
          default: ;
        endcase
      end

      if (w_err_set)      r_invalid <= 1'b1;
      else if (w_err_clr) r_invalid <= 1'b0;
    end
  end

  assign spi.tx_load        = r_tx_load;
  assign spi.tx_data        = r_tx_data;
  assign contactor_cmd_o    = r_contactor;
  assign shutdown_o         = r_shutdown;
  assign pg_shutdown_o      = r_pg_shutdown;
  assign reset_req_o        = r_reset_req;
  assign clear_errors_o     = r_clear_errors;
  assign invalid_request_o  = r_invalid;

endmodule
